// File: rtl/window_pkg.sv
// Shared definitions for the window stream controller.
//   state_e   : sequencer FSM states
//   flush_len : number of flush clken cycles needed to drain a 5-line buffer
//               of width w (two full lines plus the two-pixel grid offset)
//   is_border : 5x5 window centred at (x,y) reaches outside a w x h frame
package window_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_STREAM,
    ST_FLUSH,
    ST_DONE
  } state_e;

  function automatic int flush_len(input int w);
    return 2 * w + 2;
  endfunction

  localparam int P_WIDTH_DEF = 640;
  localparam int FLUSH_LEN   = flush_len(P_WIDTH_DEF);

  function automatic logic is_border(input int x, input int y, input int w, input int h);
    return (x < 2) || (x > w - 3) || (y < 2) || (y > h - 3);
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster-order x/y counter.
//   clr_i  : synchronous zero (wins over inc_i)
//   inc_i  : advance one position; x wraps at W-1, then y advances (wraps at H-1)
//   x_o/y_o: current position
//   last_o : position is (W-1, H-1)
module raster_counter #(
  parameter int W  = 640,
  parameter int H  = 480,
  parameter int CW = 10
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [CW-1:0] x_o,
  output logic [CW-1:0] y_o,
  output logic          last_o
);

  localparam logic [CW-1:0] XMAX = CW'(W - 1);
  localparam logic [CW-1:0] YMAX = CW'(H - 1);

  logic [CW-1:0] x_q, y_q;

  always_ff @(posedge clk) begin
    if (!reset_n || clr_i) begin
      x_q <= '0;
      y_q <= '0;
    end else if (inc_i) begin
      if (x_q == XMAX) begin
        x_q <= '0;
        y_q <= (y_q == YMAX) ? '0 : y_q + CW'(1);
      end else begin
        x_q <= x_q + CW'(1);
      end
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign last_o = (x_q == XMAX) && (y_q == YMAX);

endmodule

// File: rtl/window_stream_ctrl.sv
// Raster sequencer for a 5-line window buffer.
// Takes an upstream pixel stream, drives the buffer's shiftin/clken/ram_clr,
// and tags each buffer grid update with a window strobe, centre coordinates
// and a border flag. After the last pixel the buffer is flushed with zeros so
// every pixel of the frame appears as a window centre exactly once.
//   clk, reset_n          : clock, synchronous active-low reset
//   iSof                  : start of frame (aborts any frame in progress)
//   iValid/iPixel/oReady  : upstream pixel handshake
//   oShiftin/oClken/oRamClr : buffer controls
//   oWinValid/oCenterX/oCenterY/oBorder : window tag, aligned with grid update
//   oFrameDone            : one-cycle pulse after the last window
module window_stream_ctrl
  import window_pkg::*;
#(
  parameter int P_WIDTH        = 640,
  parameter int P_HEIGHT       = 480,
  parameter int p_bit_width_in = 24,
  parameter int P_CW           = 10
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      iSof,
  input  logic                      iValid,
  input  logic [p_bit_width_in-1:0] iPixel,
  output logic                      oReady,
  output logic [p_bit_width_in-1:0] oShiftin,
  output logic                      oClken,
  output logic                      oRamClr,
  output logic                      oWinValid,
  output logic [P_CW-1:0]           oCenterX,
  output logic [P_CW-1:0]           oCenterY,
  output logic                      oBorder,
  output logic                      oFrameDone
);

  localparam int              FL   = flush_len(P_WIDTH);
  localparam int              FW   = $clog2(FL + 1);
  localparam logic [FW-1:0]   FL_V = FW'(FL);

  state_e            state_q;
  logic [FW-1:0]     fcnt_q;   // flush cycles remaining
  logic [FW-1:0]     kcnt_q;   // clken count since CLEAR, saturating at FL
  logic              win_q, border_q, done_q;
  logic [P_CW-1:0]   cx_q, cy_q;

  logic              accept, win_d, clr;
  logic [P_CW-1:0]   in_x, in_y, c_x, c_y;
  logic              in_last, c_last;

  // iSof wins over iValid: the pixel presented with it is dropped.
  assign accept   = (state_q == ST_STREAM) && iValid && !iSof;
  assign oReady   = (state_q == ST_STREAM);
  assign oClken   = accept || (state_q == ST_FLUSH);
  assign oShiftin = (state_q == ST_STREAM) ? iPixel : '0;
  assign oRamClr  = (state_q == ST_CLEAR);
  assign clr      = (state_q == ST_CLEAR);

  // Once FL clkens have primed the buffer, every further clken completes a
  // window; the registered strobe lines up with the grid update.
  assign win_d = oClken && !iSof && (kcnt_q == FL_V);

  raster_counter #(.W(P_WIDTH), .H(P_HEIGHT), .CW(P_CW)) u_in_cnt (
    .clk(clk), .reset_n(reset_n), .clr_i(clr), .inc_i(accept),
    .x_o(in_x), .y_o(in_y), .last_o(in_last)
  );

  raster_counter #(.W(P_WIDTH), .H(P_HEIGHT), .CW(P_CW)) u_c_cnt (
    .clk(clk), .reset_n(reset_n), .clr_i(clr), .inc_i(win_d),
    .x_o(c_x), .y_o(c_y), .last_o(c_last)
  );

  logic unused_sig;
  assign unused_sig = ^{in_x, in_y, c_last};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      fcnt_q   <= '0;
      kcnt_q   <= '0;
      win_q    <= 1'b0;
      border_q <= 1'b0;
      done_q   <= 1'b0;
      cx_q     <= '0;
      cy_q     <= '0;
    end else begin
      win_q  <= win_d;
      done_q <= (state_q == ST_DONE);
      if (win_d) begin
        cx_q     <= c_x;
        cy_q     <= c_y;
        border_q <= is_border(int'(c_x), int'(c_y), P_WIDTH, P_HEIGHT);
      end
      if (oClken && kcnt_q != FL_V) kcnt_q <= kcnt_q + FW'(1);

      if (iSof) begin
        state_q <= ST_CLEAR;
      end else begin
        case (state_q)
          ST_IDLE: ;
          ST_CLEAR: begin
            kcnt_q  <= '0;
            state_q <= ST_STREAM;
          end
          ST_STREAM: begin
            if (accept && in_last) begin
              fcnt_q  <= FL_V;
              state_q <= ST_FLUSH;
            end
          end
          ST_FLUSH: begin
            fcnt_q <= fcnt_q - FW'(1);
            if (fcnt_q == FW'(1)) state_q <= ST_DONE;
          end
          ST_DONE:  state_q <= ST_IDLE;
          default:  state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign oWinValid  = win_q;
  assign oCenterX   = cx_q;
  assign oCenterY   = cy_q;
  assign oBorder    = border_q;
  assign oFrameDone = done_q;

endmodule
